// File: rtl/gcd_engine.sv
// -----------------------------------------------------------------------------
// gcd_engine
//   Self-contained GCD unit with an integrated FSM and datapath. It computes
//   the greatest common divisor of two unsigned WIDTH-bit operands. The
//   algorithm is chosen per job, either subtractive Euclid or binary Stein.
//   Operands arrive over a ready/valid handshake. The result leaves over a
//   second ready/valid handshake. Each result is reported with the number of
//   compute (CALC) cycles it took. Exactly one job is in flight at a time.
//
// Parameters
//   WIDTH  operand/result width in bits (>= 2)
//   CNT_W  width of the cycle counter; the counter saturates at all-ones
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      engine can accept operands (high only in IDLE)
//   a_in       in   WIDTH  operand A (unsigned)
//   b_in       in   WIDTH  operand B (unsigned)
//   mode       in   1      0 = subtractive Euclid, 1 = binary Stein
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts the result
//   gcd_out    out  WIDTH  GCD(A,B); GCD(0,x) = x, GCD(0,0) = 0
//   cycles     out  CNT_W  CALC cycles spent on this result
// -----------------------------------------------------------------------------
module gcd_engine #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] gcd_out,
   output logic [CNT_W-1:0] cycles
);

   // The Stein factor-of-two count k never exceeds WIDTH-1. Both operands
   // can only be halved together while both are non-zero and even.
   localparam int K_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [K_W-1:0]   k_r;
   logic             mode_r;
   logic [CNT_W-1:0] cnt;

   logic             term;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] a_nxt;
   logic [WIDTH-1:0] b_nxt;
   logic [K_W-1:0]   k_nxt;

   // Saturating increment. The counter sticks at all-ones and does not wrap.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Subtractive Euclid step. The smaller operand is always subtracted from
   // the larger one, so the unsigned difference never wraps.
   function automatic logic [2*WIDTH-1:0] euclid_step(input logic [WIDTH-1:0] a,
                                                      input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] na;
      logic [WIDTH-1:0] nb;
      na = a;
      nb = b;
      if (a > b) na = a - b;
      else       nb = b - a;
      return {na, nb};
   endfunction

   // Combinational step. The termination test is made on the current A and B.
   // It takes priority over the step.
   always_comb begin
      term  = (a_r == '0) || (b_r == '0) || (a_r == b_r);
      res   = (a_r == '0) ? (b_r << k_r) : (a_r << k_r);
      a_nxt = a_r;
      b_nxt = b_r;
      k_nxt = k_r;
      if (!mode_r) begin
         {a_nxt, b_nxt} = euclid_step(a_r, b_r);
      end else begin
         case ({a_r[0], b_r[0]})
            2'b00: begin
               // Both even: a common factor of two is pulled out and counted in k.
               a_nxt = a_r >> 1;
               b_nxt = b_r >> 1;
               k_nxt = k_r + K_W'(1);
            end
            2'b01:   a_nxt = a_r >> 1;
            2'b10:   b_nxt = b_r >> 1;
            default: begin
               // Both odd: the difference is even, so it is halved in the same step.
               if (a_r > b_r) a_nxt = (a_r - b_r) >> 1;
               else           b_nxt = (b_r - a_r) >> 1;
            end
         endcase
      end
   end

   // Control FSM and datapath registers. All outputs are registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         gcd_out   <= '0;
         cycles    <= '0;
         a_r       <= '0;
         b_r       <= '0;
         k_r       <= '0;
         mode_r    <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               // in_ready is registered, so it rises one edge after reset
               // is released.
               if (in_valid && in_ready) begin
                  a_r      <= a_in;
                  b_r      <= b_in;
                  k_r      <= '0;
                  cnt      <= '0;
                  mode_r   <= mode;
                  in_ready <= 1'b0;
                  state    <= CALC;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            CALC: begin
               cnt <= sat_inc(cnt);
               if (term) begin
                  gcd_out   <= res;
                  cycles    <= sat_inc(cnt);
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  a_r <= a_nxt;
                  b_r <= b_nxt;
                  k_r <= k_nxt;
               end
            end
            DONE: begin
               // gcd_out and cycles stay as they are after the handshake.
               // They change only when the next result is loaded.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_engine.sv
// -----------------------------------------------------------------------------
// tb_gcd_engine
//   Directed, table-driven bench for gcd_engine (WIDTH=16, CNT_W=16).
//   Latency is counted as the number of rising edges from the accept edge to
//   the first edge after which out_valid is high. It must equal cycles.
// -----------------------------------------------------------------------------
module tb_gcd_engine;

   localparam int WIDTH = 16;
   localparam int CNT_W = 16;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] gcd_out;
   logic [CNT_W-1:0] cycles;

   int n_cmp;
   int n_bad;

   gcd_engine #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_in      (a_in),
      .b_in      (b_in),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .gcd_out   (gcd_out),
      .cycles    (cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        m;
      logic [15:0] g;
      logic [15:0] c;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Runs one job and returns the result and the latency. The job is
   // presented at a negedge and accepted at the following posedge. Right
   // after the accept, the mode input is flipped to check that the engine
   // ignores it.
   task automatic run_job(input logic [15:0] a, input logic [15:0] b, input logic m,
                          output logic [15:0] g, output logic [15:0] c, output int lat);
      int w;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) check("in_ready_wait", 32'(in_ready), 32'd1);
      a_in     = a;
      b_in     = b;
      mode     = m;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      mode     = ~m;
      lat      = 0;
      while (!out_valid && lat < 70000) begin
         @(posedge clk);
         #1;
         lat++;
      end
      g = gcd_out;
      c = cycles;
   endtask

   // Completes the output handshake and checks that the engine is back in IDLE.
   task automatic release_result(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_out_valid_clr"}, 32'(out_valid), 32'd0);
      check({tag, "_in_ready_set"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      vec_t vecs[16];
      logic [15:0] g;
      logic [15:0] c;
      int lat;
      n_cmp = 0;
      n_bad = 0;

      vecs[0]  = '{16'd48,     16'd18, 1'b0, 16'd6,  16'd5};
      vecs[1]  = '{16'd48,     16'd18, 1'b1, 16'd6,  16'd6};
      vecs[2]  = '{16'd64,     16'd96, 1'b1, 16'd32, 16'd8};
      vecs[3]  = '{16'd64,     16'd96, 1'b0, 16'd32, 16'd3};
      vecs[4]  = '{16'd0,      16'd0,  1'b0, 16'd0,  16'd1};
      vecs[5]  = '{16'd0,      16'd35, 1'b0, 16'd35, 16'd1};
      vecs[6]  = '{16'd35,     16'd0,  1'b0, 16'd35, 16'd1};
      vecs[7]  = '{16'd0,      16'd0,  1'b1, 16'd0,  16'd1};
      vecs[8]  = '{16'd0,      16'd35, 1'b1, 16'd35, 16'd1};
      vecs[9]  = '{16'd35,     16'd0,  1'b1, 16'd35, 16'd1};
      vecs[10] = '{16'd21,     16'd14, 1'b0, 16'd7,  16'd3};
      vecs[11] = '{16'd9,      16'd6,  1'b1, 16'd3,  16'd3};
      vecs[12] = '{16'd7,      16'd13, 1'b1, 16'd1,  16'd5};
      vecs[13] = '{16'hFFFF,   16'd1,  1'b1, 16'd1,  16'd16};
      vecs[14] = '{16'hFFFF,   16'd1,  1'b0, 16'd1,  16'hFFFF};
      vecs[15] = '{16'd9,      16'd6,  1'b0, 16'd3,  16'd3};

      // Reset state
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a_in      = '0;
      b_in      = '0;
      mode      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_gcd_out", 32'(gcd_out), 32'd0);
      check("rst_cycles", 32'(cycles), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_rel_in_ready_low", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      check("rst_rel_in_ready_high", 32'(in_ready), 32'd1);

      // Table-driven vectors
      for (int i = 0; i < 16; i++) begin
         run_job(vecs[i].a, vecs[i].b, vecs[i].m, g, c, lat);
         check($sformatf("v%0d_gcd", i), 32'(g), 32'(vecs[i].g));
         check($sformatf("v%0d_cycles", i), 32'(c), 32'(vecs[i].c));
         check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].c));
         release_result($sformatf("v%0d", i));
      end

      // Backpressure: the result is held for 20 cycles while a new job is offered.
      run_job(16'd48, 16'd18, 1'b0, g, c, lat);
      check("bp_gcd", 32'(g), 32'd6);
      @(negedge clk);
      a_in     = 16'd21;
      b_in     = 16'd14;
      mode     = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         mode = ~mode;
         check($sformatf("bp%0d_out_valid", i), 32'(out_valid), 32'd1);
         check($sformatf("bp%0d_gcd", i), 32'(gcd_out), 32'd6);
         check($sformatf("bp%0d_cycles", i), 32'(cycles), 32'd5);
         check($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      release_result("bp");
      check("bp_hold_gcd_after", 32'(gcd_out), 32'd6);
      run_job(16'd21, 16'd14, 1'b0, g, c, lat);
      check("bp_next_gcd", 32'(g), 32'd7);
      check("bp_next_cycles", 32'(c), 32'd3);
      release_result("bp_next");

      // Asynchronous reset in the middle of a long CALC
      @(negedge clk);
      a_in     = 16'd1000;
      b_in     = 16'd3;
      mode     = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_in_ready", 32'(in_ready), 32'd0);
      check("arst_gcd_out", 32'(gcd_out), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("arst_hold_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("arst_idle_in_ready", 32'(in_ready), 32'd1);
      check("arst_idle_out_valid", 32'(out_valid), 32'd0);
      run_job(16'd9, 16'd6, 1'b0, g, c, lat);
      check("arst_next_gcd", 32'(g), 32'd3);
      check("arst_next_cycles", 32'(c), 32'd3);
      check("arst_next_latency", 32'(lat), 32'd3);
      release_result("arst_next");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
